// File: rtl/i2c_accel_target.sv
// I2C target presenting an MPU-6050-style register map: pointer/config writes,
// accelerometer sample reads, and sample registers that stay coherent within a transaction.
module i2c_accel_target #(
    parameter logic [6:0] DEV_ADDR     = 7'h68,
    parameter logic [7:0] WHO_AM_I_VAL = 8'h68
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    input  logic [15:0] accel_x,
    input  logic [15:0] accel_y,
    input  logic [15:0] accel_z,
    input  logic        sample_valid,
    output logic [7:0]  pwr_mgmt_1,
    output logic [7:0]  smplrt_div,
    output logic [7:0]  config_r,
    output logic [7:0]  gyro_config,
    output logic [7:0]  accel_config,
    output logic        cfg_wr,
    output logic        busy
);

    typedef enum logic [3:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StReg,
        StRegAck,
        StWdata,
        StWdataAck,
        StRdata,
        StRdataAck,
        StWaitStop
    } state_e;

    // Synchronizer and edge-register stages; idle bus level is high.
    logic scl_meta, scl_sync, scl_prev;
    logic sda_meta, sda_sync, sda_prev;
    logic scl_rise, scl_fall, start_det, stop_det;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  sr_q, sr_d;
    logic [7:0]  ptr_q, ptr_d;
    logic        rw_q, rw_d;
    logic        sda_oe_q, sda_oe_d;
    logic        busy_q, busy_d;
    logic        cfg_wr_q, cfg_wr_d;
    logic [7:0]  pwr_q, pwr_d;
    logic [7:0]  smplrt_q, smplrt_d;
    logic [7:0]  config_q, config_d;
    logic [7:0]  gyro_q, gyro_d;
    logic [7:0]  accel_cfg_q, accel_cfg_d;
    logic [15:0] ax_q, ax_d, ay_q, ay_d, az_q, az_d;
    logic        pend_q, pend_d;
    logic [15:0] pend_x_q, pend_x_d, pend_y_q, pend_y_d, pend_z_q, pend_z_d;

    logic [7:0]  rd_data;
    logic [7:0]  byte_in;
    logic        load_rd;

    // Two-stage synchronizers followed by one register for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_meta <= 1'b1;
            scl_sync <= 1'b1;
            scl_prev <= 1'b1;
            sda_meta <= 1'b1;
            sda_sync <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_meta <= scl_in;
            scl_sync <= scl_meta;
            scl_prev <= scl_sync;
            sda_meta <= sda_in;
            sda_sync <= sda_meta;
            sda_prev <= sda_sync;
        end
    end

    assign scl_rise  = scl_sync & ~scl_prev;
    assign scl_fall  = ~scl_sync & scl_prev;
    assign start_det = scl_sync & scl_prev & sda_prev & ~sda_sync;
    assign stop_det  = scl_sync & scl_prev & ~sda_prev & sda_sync;

    // Register map read mux, addressed by the current pointer.
    always_comb begin
        rd_data = 8'h00;
        case (ptr_q)
            8'h19:   rd_data = smplrt_q;
            8'h1A:   rd_data = config_q;
            8'h1B:   rd_data = gyro_q;
            8'h1C:   rd_data = accel_cfg_q;
            8'h3B:   rd_data = ax_q[15:8];
            8'h3C:   rd_data = ax_q[7:0];
            8'h3D:   rd_data = ay_q[15:8];
            8'h3E:   rd_data = ay_q[7:0];
            8'h3F:   rd_data = az_q[15:8];
            8'h40:   rd_data = az_q[7:0];
            8'h6B:   rd_data = pwr_q;
            8'h75:   rd_data = WHO_AM_I_VAL;
            default: rd_data = 8'h00;
        endcase
    end

    // Bus protocol FSM, register writes and sample-buffer handling.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sr_d        = sr_q;
        ptr_d       = ptr_q;
        rw_d        = rw_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        cfg_wr_d    = 1'b0;
        pwr_d       = pwr_q;
        smplrt_d    = smplrt_q;
        config_d    = config_q;
        gyro_d      = gyro_q;
        accel_cfg_d = accel_cfg_q;
        ax_d        = ax_q;
        ay_d        = ay_q;
        az_d        = az_q;
        pend_d      = pend_q;
        pend_x_d    = pend_x_q;
        pend_y_d    = pend_y_q;
        pend_z_d    = pend_z_q;
        load_rd     = 1'b0;
        byte_in     = {sr_q[6:0], sda_sync};

        if (start_det) begin
            state_d  = StAddr;
            cnt_d    = 3'd0;
            sda_oe_d = 1'b0;
        end else if (stop_det) begin
            state_d  = StIdle;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                StAddr: begin
                    if (scl_rise) begin
                        sr_d  = byte_in;
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            if (byte_in[7:1] == DEV_ADDR) begin
                                busy_d  = 1'b1;
                                rw_d    = byte_in[0];
                                state_d = StAddrAck;
                            end else begin
                                state_d = StWaitStop;
                            end
                        end
                    end
                end
                StReg: begin
                    if (scl_rise) begin
                        sr_d  = byte_in;
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            ptr_d   = byte_in;
                            state_d = StRegAck;
                        end
                    end
                end
                StWdata: begin
                    if (scl_rise) begin
                        sr_d  = byte_in;
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            // Read-only and unmapped targets are acknowledged but dropped.
                            case (ptr_q)
                                8'h19: begin smplrt_d    = byte_in; cfg_wr_d = 1'b1; end
                                8'h1A: begin config_d    = byte_in; cfg_wr_d = 1'b1; end
                                8'h1B: begin gyro_d      = byte_in; cfg_wr_d = 1'b1; end
                                8'h1C: begin accel_cfg_d = byte_in; cfg_wr_d = 1'b1; end
                                8'h6B: begin pwr_d       = byte_in; cfg_wr_d = 1'b1; end
                                default: ;
                            endcase
                            ptr_d   = ptr_q + 8'd1;
                            state_d = StWdataAck;
                        end
                    end
                end
                StAddrAck, StRegAck, StWdataAck: begin
                    // First fall starts the ACK drive, the second fall ends it.
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            cnt_d    = 3'd0;
                            if (state_q == StAddrAck && rw_q) begin
                                load_rd = 1'b1;
                            end else if (state_q == StAddrAck) begin
                                state_d = StReg;
                            end else begin
                                state_d = StWdata;
                            end
                        end
                    end
                end
                StRdata: begin
                    if (scl_fall) begin
                        if (cnt_q == 3'd7) begin
                            sda_oe_d = 1'b0;
                            state_d  = StRdataAck;
                        end else begin
                            sr_d     = {sr_q[6:0], 1'b0};
                            sda_oe_d = ~sr_q[6];
                            cnt_d    = cnt_q + 3'd1;
                        end
                    end
                end
                StRdataAck: begin
                    if (scl_rise && sda_sync) begin
                        state_d = StWaitStop;
                    end else if (scl_fall) begin
                        load_rd = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        // Latch the next outgoing byte and put its MSB on the bus at the same fall.
        if (load_rd) begin
            sr_d     = rd_data;
            ptr_d    = ptr_q + 8'd1;
            sda_oe_d = ~rd_data[7];
            cnt_d    = 3'd0;
            state_d  = StRdata;
        end

        // A deferred sample lands once the bus is free; a fresh idle pulse is newer and wins.
        if (pend_q && !busy_q) begin
            ax_d   = pend_x_q;
            ay_d   = pend_y_q;
            az_d   = pend_z_q;
            pend_d = 1'b0;
        end
        if (sample_valid) begin
            if (busy_q) begin
                pend_d   = 1'b1;
                pend_x_d = accel_x;
                pend_y_d = accel_y;
                pend_z_d = accel_z;
            end else begin
                ax_d   = accel_x;
                ay_d   = accel_y;
                az_d   = accel_z;
                pend_d = 1'b0;
            end
        end
    end

    // State and register file; reset releases SDA immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= 3'd0;
            sr_q        <= 8'h00;
            ptr_q       <= 8'h00;
            rw_q        <= 1'b0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            cfg_wr_q    <= 1'b0;
            pwr_q       <= 8'h40;
            smplrt_q    <= 8'h00;
            config_q    <= 8'h00;
            gyro_q      <= 8'h00;
            accel_cfg_q <= 8'h00;
            ax_q        <= 16'h0000;
            ay_q        <= 16'h0000;
            az_q        <= 16'h0000;
            pend_q      <= 1'b0;
            pend_x_q    <= 16'h0000;
            pend_y_q    <= 16'h0000;
            pend_z_q    <= 16'h0000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sr_q        <= sr_d;
            ptr_q       <= ptr_d;
            rw_q        <= rw_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            cfg_wr_q    <= cfg_wr_d;
            pwr_q       <= pwr_d;
            smplrt_q    <= smplrt_d;
            config_q    <= config_d;
            gyro_q      <= gyro_d;
            accel_cfg_q <= accel_cfg_d;
            ax_q        <= ax_d;
            ay_q        <= ay_d;
            az_q        <= az_d;
            pend_q      <= pend_d;
            pend_x_q    <= pend_x_d;
            pend_y_q    <= pend_y_d;
            pend_z_q    <= pend_z_d;
        end
    end

    assign sda_oe       = sda_oe_q;
    assign busy         = busy_q;
    assign cfg_wr       = cfg_wr_q;
    assign pwr_mgmt_1   = pwr_q;
    assign smplrt_div   = smplrt_q;
    assign config_r     = config_q;
    assign gyro_config  = gyro_q;
    assign accel_config = accel_cfg_q;

endmodule
